// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dmem_arb_pkg;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_M0   = 2'd1,
      OWN_M1   = 2'd2
   } owner_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_arb_chan.sv
// One arbitration channel: owner FSM, round-robin pointer and m1 starvation counter.
// Valid/ready: req is held stable until the slave answers valid; transfer when grant and valid are both 1.
module dmem_arb_chan
   import dmem_arb_pkg::*;
#(
   parameter int ARB_MODE = ARB_RR,
   parameter int MAX_WAIT = 8
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       req0_i,
   input  logic       req1_i,
   input  logic       s_valid_i,
   output logic [1:0] grant_o,
   output logic       hs_o
);

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   state_e     state_q, state_d;
   logic       ptr_q, ptr_d;
   logic [3:0] cnt_q, cnt_d;
   logic       pick1;

   always_comb begin
      pick1   = 1'b0;
      grant_o = 2'b00;
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;

      if (req1_i && !req0_i) begin
         pick1 = 1'b1;
      end else if (req1_i && req0_i) begin
         pick1 = (ARB_MODE == ARB_FIXED) ? (cnt_q >= MAX_WAIT_C) : ptr_q;
      end

      // An owner that drops its request loses the grant immediately.
      unique case (state_q)
         IDLE:    if (req0_i || req1_i) grant_o = pick1 ? 2'b10 : 2'b01;
         OWN0:    grant_o = {1'b0, req0_i};
         OWN1:    grant_o = {req1_i, 1'b0};
         default: grant_o = 2'b00;
      endcase
      if (reset_i) grant_o = 2'b00;

      hs_o = (|grant_o) && s_valid_i;

      unique case (state_q)
         IDLE:    if ((|grant_o) && !s_valid_i) state_d = grant_o[1] ? OWN1 : OWN0;
         OWN0:    if (!req0_i || s_valid_i) state_d = IDLE;
         OWN1:    if (!req1_i || s_valid_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (hs_o) ptr_d = grant_o[0];

      if (hs_o && grant_o[1]) begin
         cnt_d = 4'd0;
      end else if (state_q == IDLE && req1_i && !grant_o[1] && cnt_q != 4'hF) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/dmem_arb.sv
// Two-master data-memory arbiter: independent write and read channels plus read-return routing.
module dmem_arb
   import dmem_arb_pkg::*;
#(
   parameter int ARB_MODE = ARB_RR,
   parameter int MAX_WAIT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_wready,
   output logic        m0_wvalid,
   input  logic [31:0] m0_waddr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   input  logic        m0_rready,
   output logic        m0_rvalid,
   input  logic [31:0] m0_raddr,
   output logic        m0_rresp,
   output logic [31:0] m0_rdata,
   input  logic        m1_wready,
   output logic        m1_wvalid,
   input  logic [31:0] m1_waddr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   input  logic        m1_rready,
   output logic        m1_rvalid,
   input  logic [31:0] m1_raddr,
   output logic        m1_rresp,
   output logic [31:0] m1_rdata,
   output logic        s_wready,
   input  logic        s_wvalid,
   output logic [31:0] s_waddr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   output logic        s_rready,
   input  logic        s_rvalid,
   output logic [31:0] s_raddr,
   input  logic        s_rresp,
   input  logic [31:0] s_rdata,
   output logic [1:0]  wgrant,
   output logic [1:0]  rgrant
);

   logic   w_hs, r_hs;
   owner_e ret_q, ret_d;

   dmem_arb_chan #(.ARB_MODE(ARB_MODE), .MAX_WAIT(MAX_WAIT)) u_wr_chan (
      .clk_i    (clk),
      .reset_i  (reset),
      .req0_i   (m0_wready),
      .req1_i   (m1_wready),
      .s_valid_i(s_wvalid),
      .grant_o  (wgrant),
      .hs_o     (w_hs)
   );

   dmem_arb_chan #(.ARB_MODE(ARB_MODE), .MAX_WAIT(MAX_WAIT)) u_rd_chan (
      .clk_i    (clk),
      .reset_i  (reset),
      .req0_i   (m0_rready),
      .req1_i   (m1_rready),
      .s_valid_i(s_rvalid),
      .grant_o  (rgrant),
      .hs_o     (r_hs)
   );

   assign m0_wvalid = w_hs && wgrant[0];
   assign m1_wvalid = w_hs && wgrant[1];
   assign m0_rvalid = r_hs && rgrant[0];
   assign m1_rvalid = r_hs && rgrant[1];
   assign s_wready  = |wgrant;
   assign s_rready  = |rgrant;

   always_comb begin
      s_waddr = '0;
      s_wdata = '0;
      s_wstrb = '0;
      s_raddr = '0;
      if (wgrant[0]) begin
         s_waddr = m0_waddr;
         s_wdata = m0_wdata;
         s_wstrb = m0_wstrb;
      end else if (wgrant[1]) begin
         s_waddr = m1_waddr;
         s_wdata = m1_wdata;
         s_wstrb = m1_wstrb;
      end
      if (rgrant[0])      s_raddr = m0_raddr;
      else if (rgrant[1]) s_raddr = m1_raddr;
   end

   // Return owner tracks only the most recent read handshake, so back-to-back reads overlap cleanly.
   always_comb begin
      ret_d = OWN_NONE;
      if (r_hs) ret_d = rgrant[1] ? OWN_M1 : OWN_M0;
   end

   always_ff @(posedge clk) begin
      if (reset) ret_q <= OWN_NONE;
      else       ret_q <= ret_d;
   end

   assign m0_rresp = !reset && (ret_q == OWN_M0) && s_rresp;
   assign m1_rresp = !reset && (ret_q == OWN_M1) && s_rresp;
   assign m0_rdata = reset ? '0 : s_rdata;
   assign m1_rdata = reset ? '0 : s_rdata;

endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb: round-robin instance plus a fixed-priority instance (MAX_WAIT=3) on shared inputs.
module tb_dmem_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_wready, m1_wready, m0_rready, m1_rready;
   logic [31:0] m0_waddr, m0_wdata, m1_waddr, m1_wdata, m0_raddr, m1_raddr;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        s_wvalid, s_rvalid, s_rresp;
   logic [31:0] s_rdata;

   logic        m0_wvalid, m0_rvalid, m0_rresp, m1_wvalid, m1_rvalid, m1_rresp;
   logic [31:0] m0_rdata, m1_rdata, s_waddr, s_wdata, s_raddr;
   logic [3:0]  s_wstrb;
   logic        s_wready, s_rready;
   logic [1:0]  wgrant, rgrant;

   logic        f_m0_wvalid, f_m0_rvalid, f_m0_rresp, f_m1_wvalid, f_m1_rvalid, f_m1_rresp;
   logic [31:0] f_m0_rdata, f_m1_rdata, f_s_waddr, f_s_wdata, f_s_raddr;
   logic [3:0]  f_s_wstrb;
   logic        f_s_wready, f_s_rready;
   logic [1:0]  f_wgrant, f_rgrant;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [1:0]  exp_q[$];
   logic [1:0]  exp_g;

   always #5 clk = ~clk;

   dmem_arb #(.ARB_MODE(0), .MAX_WAIT(8)) dut_rr (
      .clk(clk), .reset(reset),
      .m0_wready(m0_wready), .m0_wvalid(m0_wvalid), .m0_waddr(m0_waddr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_rready(m0_rready), .m0_rvalid(m0_rvalid), .m0_raddr(m0_raddr),
      .m0_rresp(m0_rresp), .m0_rdata(m0_rdata),
      .m1_wready(m1_wready), .m1_wvalid(m1_wvalid), .m1_waddr(m1_waddr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_rready(m1_rready), .m1_rvalid(m1_rvalid), .m1_raddr(m1_raddr),
      .m1_rresp(m1_rresp), .m1_rdata(m1_rdata),
      .s_wready(s_wready), .s_wvalid(s_wvalid), .s_waddr(s_waddr), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_rready(s_rready), .s_rvalid(s_rvalid), .s_raddr(s_raddr),
      .s_rresp(s_rresp), .s_rdata(s_rdata), .wgrant(wgrant), .rgrant(rgrant)
   );

   dmem_arb #(.ARB_MODE(1), .MAX_WAIT(3)) dut_fp (
      .clk(clk), .reset(reset),
      .m0_wready(m0_wready), .m0_wvalid(f_m0_wvalid), .m0_waddr(m0_waddr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_rready(m0_rready), .m0_rvalid(f_m0_rvalid), .m0_raddr(m0_raddr),
      .m0_rresp(f_m0_rresp), .m0_rdata(f_m0_rdata),
      .m1_wready(m1_wready), .m1_wvalid(f_m1_wvalid), .m1_waddr(m1_waddr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_rready(m1_rready), .m1_rvalid(f_m1_rvalid), .m1_raddr(m1_raddr),
      .m1_rresp(f_m1_rresp), .m1_rdata(f_m1_rdata),
      .s_wready(f_s_wready), .s_wvalid(s_wvalid), .s_waddr(f_s_waddr), .s_wdata(f_s_wdata),
      .s_wstrb(f_s_wstrb), .s_rready(f_s_rready), .s_rvalid(s_rvalid), .s_raddr(f_s_raddr),
      .s_rresp(s_rresp), .s_rdata(s_rdata), .wgrant(f_wgrant), .rgrant(f_rgrant)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_wready = 0; m1_wready = 0; m0_rready = 0; m1_rready = 0;
      m0_waddr = 0; m0_wdata = 0; m0_wstrb = 0; m1_waddr = 0; m1_wdata = 0; m1_wstrb = 0;
      m0_raddr = 0; m1_raddr = 0;
      s_wvalid = 0; s_rvalid = 0; s_rresp = 0; s_rdata = 0;
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      tick();

      // Outputs stay 0 in reset even with a live request
      m0_wready = 1; m0_waddr = 32'hA0; s_wvalid = 1;
      @(negedge clk);
      check("rst_wgrant", wgrant, 2'b00);
      check("rst_s_wready", s_wready, 1'b0);
      check("rst_m0_wvalid", m0_wvalid, 1'b0);
      check("rst_s_waddr", s_waddr, 32'h0);
      tick();

      // Both masters write together: m0 then m1
      reset = 0;
      m1_wready = 1; m1_waddr = 32'hB0; m1_wdata = 32'h1111; m1_wstrb = 4'hF;
      m0_wdata = 32'h2222; m0_wstrb = 4'h3;
      @(negedge clk);
      check("wr_c0_wgrant", wgrant, 2'b01);
      check("wr_c0_m0_wvalid", m0_wvalid, 1'b1);
      check("wr_c0_m1_wvalid", m1_wvalid, 1'b0);
      check("wr_c0_s_waddr", s_waddr, 32'hA0);
      check("wr_c0_s_wstrb", s_wstrb, 4'h3);
      tick();
      m0_wready = 0;
      @(negedge clk);
      check("wr_c1_wgrant", wgrant, 2'b10);
      check("wr_c1_m1_wvalid", m1_wvalid, 1'b1);
      check("wr_c1_s_wdata", s_wdata, 32'h1111);
      tick();
      m1_wready = 0; s_wvalid = 0;
      @(negedge clk);
      check("wr_idle_wgrant", wgrant, 2'b00);
      check("wr_idle_s_wready", s_wready, 1'b0);
      check("wr_idle_s_waddr", s_waddr, 32'h0);
      tick();

      // m0 reads with 3 wait cycles; m1 arrives late and must wait
      m0_rready = 1; m0_raddr = 32'h1000;
      @(negedge clk);
      check("rd_c0_rgrant", rgrant, 2'b01);
      check("rd_c0_s_raddr", s_raddr, 32'h1000);
      check("rd_c0_m0_rvalid", m0_rvalid, 1'b0);
      tick();
      m1_rready = 1; m1_raddr = 32'h3000;
      for (int i = 1; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("rd_c%0d_rgrant", i), rgrant, 2'b01);
         check($sformatf("rd_c%0d_m1_rvalid", i), m1_rvalid, 1'b0);
         check($sformatf("rd_c%0d_s_raddr", i), s_raddr, 32'h1000);
         tick();
      end
      s_rvalid = 1;
      @(negedge clk);
      check("rd_c3_m0_rvalid", m0_rvalid, 1'b1);
      check("rd_c3_rgrant", rgrant, 2'b01);
      check("rd_c3_m0_rresp", m0_rresp, 1'b0);
      tick();
      m0_rready = 0; s_rresp = 1; s_rdata = 32'hDEADBEEF;
      @(negedge clk);
      check("rd_c4_m0_rresp", m0_rresp, 1'b1);
      check("rd_c4_m1_rresp", m1_rresp, 1'b0);
      check("rd_c4_m0_rdata", m0_rdata, 32'hDEADBEEF);
      check("rd_c4_m1_rdata", m1_rdata, 32'hDEADBEEF);
      check("rd_c4_rgrant", rgrant, 2'b10);
      check("rd_c4_m1_rvalid", m1_rvalid, 1'b1);
      check("rd_c4_s_raddr", s_raddr, 32'h3000);
      tick();
      m1_rready = 0; s_rvalid = 0;
      @(negedge clk);
      check("rd_c5_m1_rresp", m1_rresp, 1'b1);
      check("rd_c5_m0_rresp", m0_rresp, 1'b0);
      check("rd_c5_rgrant", rgrant, 2'b00);
      tick();

      // Concurrent write (m0) and read (m1) in one cycle
      idle_inputs();
      m0_wready = 1; m0_waddr = 32'h2000; m0_wdata = 32'hCAFE0001; m0_wstrb = 4'hC;
      m1_rready = 1; m1_raddr = 32'h3000;
      s_wvalid = 1; s_rvalid = 1;
      @(negedge clk);
      check("cc_wgrant", wgrant, 2'b01);
      check("cc_rgrant", rgrant, 2'b10);
      check("cc_m0_wvalid", m0_wvalid, 1'b1);
      check("cc_m1_rvalid", m1_rvalid, 1'b1);
      check("cc_s_waddr", s_waddr, 32'h2000);
      check("cc_s_wdata", s_wdata, 32'hCAFE0001);
      check("cc_s_raddr", s_raddr, 32'h3000);
      tick();

      // Reset right after the m1 read handshake: no return, all outputs 0
      reset = 1; s_rresp = 1; s_rdata = 32'h12345678;
      @(negedge clk);
      check("rr_m1_rresp", m1_rresp, 1'b0);
      check("rr_m0_rresp", m0_rresp, 1'b0);
      check("rr_wgrant", wgrant, 2'b00);
      check("rr_rgrant", rgrant, 2'b00);
      check("rr_s_rready", s_rready, 1'b0);
      check("rr_m1_rvalid", m1_rvalid, 1'b0);
      check("rr_s_raddr", s_raddr, 32'h0);
      check("rr_m1_rdata", m1_rdata, 32'h0);
      tick();
      reset = 0;
      m0_wready = 1; m1_wready = 1; s_wvalid = 0;
      m0_rready = 1; m1_rready = 1; s_rvalid = 0;
      @(negedge clk);
      check("post_rst_m1_rresp", m1_rresp, 1'b0);
      check("post_rst_m0_rresp", m0_rresp, 1'b0);
      check("post_rst_wgrant_ptr", wgrant, 2'b01);
      check("post_rst_rgrant_ptr", rgrant, 2'b01);
      tick();

      // Both channels now own m0; reset must return them to IDLE
      reset = 1;
      @(negedge clk);
      check("own_rst_rgrant", rgrant, 2'b00);
      tick();
      reset = 0; m0_wready = 0; m0_rready = 0;
      @(negedge clk);
      check("own_cleared_wgrant", wgrant, 2'b10);
      check("own_cleared_rgrant", rgrant, 2'b10);
      tick();

      // Fixed priority with MAX_WAIT=3 versus round-robin on the same traffic
      idle_inputs();
      reset = 1;
      tick();
      reset = 0;
      m0_rready = 1; m0_raddr = 32'h40; m1_rready = 1; m1_raddr = 32'h80; s_rvalid = 1;
      exp_q = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         exp_g = exp_q.pop_front();
         check($sformatf("fp_rgrant_%0d", i), f_rgrant, exp_g);
         check($sformatf("fp_m0_rvalid_%0d", i), f_m0_rvalid, exp_g[0]);
         check($sformatf("fp_m1_rvalid_%0d", i), f_m1_rvalid, exp_g[1]);
         check($sformatf("rr_alt_rgrant_%0d", i), rgrant, (i % 2 == 0) ? 2'b01 : 2'b10);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
